// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared system-bus types and constants
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      WRITE,
      SPLIT,
      RLAT,
      RDATA
   } slave_port_state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/slave_port_if.sv
// rtl/slave_port_if.sv - per-slave serial bus bundle forwarded by the arbiter
interface slave_port_if;

   logic mode;
   logic wr_bus;
   logic master_valid;
   logic master_ready;
   logic rd_bus;
   logic slave_ready;
   logic slave_valid;
   logic split;

   modport master (
      output mode, wr_bus, master_valid, master_ready,
      input  rd_bus, slave_ready, slave_valid, split
   );

   modport slave (
      input  mode, wr_bus, master_valid, master_ready,
      output rd_bus, slave_ready, slave_valid, split
   );

endinterface

// File: rtl/slave_mem.sv
// rtl/slave_mem.sv - single-port synchronous RAM with registered read data
module slave_mem #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Contents and rdata are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata     <= mem[addr];
   end

endmodule

// File: rtl/slave_port.sv
// rtl/slave_port.sv - serial-to-parallel bus slave with local memory and optional read split
module slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int SPLIT_EN     = 0,
   parameter int SPLIT_CYCLES = 4
) (
   input logic         clk,
   input logic         rstn,
   slave_port_if.slave bus
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int BW    = $clog2(MAX_W + 1);
   localparam int WW    = $clog2(SPLIT_CYCLES + 1);

   localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SPLIT_CYCLES - 1);

   slave_port_state_t state, state_nxt;

   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] addr_sr;
   logic [DATA_WIDTH-1:0] data_sr;
   logic [BW-1:0]         bit_cnt;
   logic [WW-1:0]         wait_cnt;
   logic                  rlat_second;

   logic                  slave_ready, slave_valid, split;
   logic                  mem_we, mem_re;
   logic [DATA_WIDTH-1:0] mem_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      slave_ready = 1'b0;
      slave_valid = 1'b0;
      split       = 1'b0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      case (state)
         IDLE: begin
            slave_ready = 1'b1;
            if (bus.master_valid) state_nxt = ADDR;
         end
         ADDR: begin
            slave_ready = 1'b1;
            if (bus.master_valid && bit_cnt == ADDR_LAST) begin
               if (mode_q != MODE_READ) state_nxt = WDATA;
               else if (SPLIT_EN != 0)  state_nxt = SPLIT;
               else                     state_nxt = RLAT;
            end
         end
         WDATA: begin
            slave_ready = 1'b1;
            if (bus.master_valid && bit_cnt == DATA_LAST) state_nxt = WRITE;
         end
         WRITE: begin
            mem_we    = 1'b1;
            state_nxt = IDLE;
         end
         SPLIT: begin
            split = 1'b1;
            if (wait_cnt == WAIT_LAST) state_nxt = RLAT;
         end
         RLAT: begin
            mem_re = !rlat_second;
            if (rlat_second) state_nxt = RDATA;
         end
         RDATA: begin
            slave_valid = 1'b1;
            if (bus.master_ready && bit_cnt == DATA_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: shift registers and counters only move on accepted bits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q      <= 1'b0;
         addr_sr     <= '0;
         data_sr     <= '0;
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         rlat_second <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.master_valid) begin
               mode_q  <= bus.mode;
               addr_sr <= ADDR_WIDTH'(bus.wr_bus);
               bit_cnt <= BW'(1);
            end
            ADDR: begin
               wait_cnt    <= '0;
               rlat_second <= 1'b0;
               if (bus.master_valid) begin
                  addr_sr <= {addr_sr[ADDR_WIDTH-2:0], bus.wr_bus};
                  bit_cnt <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + BW'(1);
               end
            end
            WDATA: if (bus.master_valid) begin
               data_sr <= {data_sr[DATA_WIDTH-2:0], bus.wr_bus};
               bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
            end
            SPLIT: wait_cnt <= wait_cnt + WW'(1);
            RLAT: begin
               rlat_second <= !rlat_second;
               wait_cnt    <= '0;
               if (rlat_second) begin
                  data_sr <= mem_q;
                  bit_cnt <= '0;
               end
            end
            RDATA: if (bus.master_ready) begin
               data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
               bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
            end
            default: ;
         endcase
      end
   end

   slave_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (addr_sr),
      .wdata (data_sr),
      .rdata (mem_q)
   );

   assign bus.slave_ready = slave_ready;
   assign bus.slave_valid = slave_valid;
   assign bus.split       = split;
   assign bus.rd_bus      = slave_valid & data_sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_slave_port.sv
// tb/tb_slave_port.sv - directed self-checking bench for slave_port
module tb_slave_port;
   import bus_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic mode_d, wr_d, mv, mr, sel;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   slave_port_if bus0 ();
   slave_port_if bus1 ();

   slave_port u_dut0 (.clk(clk), .rstn(rstn), .bus(bus0));

   slave_port #(.SPLIT_EN(1), .SPLIT_CYCLES(4)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

   assign bus0.mode         = mode_d;
   assign bus0.wr_bus       = wr_d;
   assign bus0.master_valid = mv & ~sel;
   assign bus0.master_ready = mr & ~sel;
   assign bus1.mode         = mode_d;
   assign bus1.wr_bus       = wr_d;
   assign bus1.master_valid = mv & sel;
   assign bus1.master_ready = mr & sel;

   wire o_rd    = sel ? bus1.rd_bus      : bus0.rd_bus;
   wire o_ready = sel ? bus1.slave_ready : bus0.slave_ready;
   wire o_valid = sel ? bus1.slave_valid : bus0.slave_valid;
   wire o_split = sel ? bus1.split       : bus0.split;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // abort_at >= 0 pulses reset after that many data bits have been accepted.
   task automatic wr_txn(input logic [11:0] a, input logic [7:0] d,
                         input int gap_a, input int gap_d, input int abort_at);
      mode_d = MODE_WRITE;
      for (int i = 0; i < 12; i++) begin
         if (i == gap_a) begin
            mv = 1'b0;
            repeat (3) step();
         end
         wr_d = a[11-i];
         mv   = 1'b1;
         step();
      end
      for (int i = 0; i < 8; i++) begin
         if (i == abort_at) begin
            mv   = 1'b0;
            rstn = 1'b0;
            #1;
            chk("abort_ready", o_ready, 1'b1);
            chk("abort_valid", o_valid, 1'b0);
            chk("abort_split", o_split, 1'b0);
            chk("abort_rd",    o_rd,    1'b0);
            step();
            rstn = 1'b1;
            step();
            return;
         end
         if (i == gap_d) begin
            mv = 1'b0;
            repeat (3) step();
         end
         wr_d = d[7-i];
         mv   = 1'b1;
         step();
      end
      mv = 1'b0;
      chk("write_cycle_ready", o_ready, 1'b0);
      step();
      chk("after_write_ready", o_ready, 1'b1);
   endtask

   task automatic rd_txn(input string tag, input logic [11:0] a, input logic [7:0] exp,
                         input bit bp, input bit keep_mv, input int exp_lat, input int exp_split);
      logic [7:0] got;
      logic       held;
      int         lat;
      int         sc;
      got    = '0;
      mode_d = MODE_READ;
      for (int i = 0; i < 12; i++) begin
         wr_d = a[11-i];
         mv   = 1'b1;
         step();
      end
      mv   = keep_mv;
      wr_d = 1'b1;
      lat  = 0;
      sc   = 0;
      while (!o_valid && lat < 20) begin
         if (o_split) sc++;
         step();
         wr_d = ~wr_d;
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_split_cycles"}, sc, exp_split);
      for (int i = 0; i < 8; i++) begin
         if (bp) begin
            mr   = 1'b0;
            held = o_rd;
            step();
            chk({tag, "_hold"}, {o_valid, o_rd}, {1'b1, held});
         end
         mr  = 1'b1;
         got = {got[6:0], o_rd};
         step();
         wr_d = ~wr_d;
         mr   = 1'b0;
      end
      mv = 1'b0;
      chk({tag, "_data"}, got, exp);
      chk({tag, "_valid_drop"}, o_valid, 1'b0);
      chk({tag, "_idle_ready"}, o_ready, 1'b1);
   endtask

   initial begin
      rstn   = 1'b0;
      mode_d = 1'b0;
      wr_d   = 1'b0;
      mv     = 1'b0;
      mr     = 1'b0;
      sel    = 1'b0;
      #12;
      chk("rst_rd",     bus0.rd_bus,      1'b0);
      chk("rst_ready",  bus0.slave_ready, 1'b1);
      chk("rst_valid",  bus0.slave_valid, 1'b0);
      chk("rst_split",  bus0.split,       1'b0);
      chk("rst_split1", bus1.split,       1'b0);
      step();
      rstn = 1'b1;
      step();

      wr_txn(12'h005, 8'hA5, -1, -1, -1);
      rd_txn("rd_005", 12'h005, 8'hA5, 1'b0, 1'b0, 2, 0);

      wr_txn(12'h03C, 8'h5A, -1, -1, -1);
      rd_txn("rd_bp", 12'h03C, 8'h5A, 1'b1, 1'b0, 2, 0);

      wr_txn(12'h000, 8'h11, -1, -1, -1);
      wr_txn(12'hFFF, 8'h81, 6, 4, -1);
      rd_txn("rd_fff", 12'hFFF, 8'h81, 1'b0, 1'b0, 2, 0);
      rd_txn("rd_000", 12'h000, 8'h11, 1'b0, 1'b0, 2, 0);

      wr_txn(12'h010, 8'h33, -1, -1, -1);
      wr_txn(12'h010, 8'hFF, -1, -1, 5);
      rd_txn("rd_010", 12'h010, 8'h33, 1'b0, 1'b0, 2, 0);

      rd_txn("rd_ign", 12'h005, 8'hA5, 1'b0, 1'b1, 2, 0);

      sel = 1'b1;
      step();
      wr_txn(12'h020, 8'h7E, -1, -1, -1);
      rd_txn("rd_split", 12'h020, 8'h7E, 1'b0, 1'b0, 6, 4);

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/slave_port.md
# slave_port

- Serial-to-parallel slave endpoint on the system bus, downstream of the arbiter.
- Accepts the per-slave signal bundle the arbiter forwards after address decode: mode, serial write bus, master valid/ready in; serial read bus, slave ready/valid, split out.
- Deserialises the in-slave address and write data, then performs a single-word access on a local synchronous memory.
- Serialises read data back to the master, and can optionally split long reads so the arbiter can release the bus.

## Interface
- ADDR_WIDTH, 12: in-slave word address bits, minimum 2; memory depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: word width in bits, minimum 2.
- SPLIT_EN, 0: when 1, every read transaction goes through SPLIT.
- SPLIT_CYCLES, 4: number of cycles split is held high, minimum 1.

Ports:
- clk  in  1  clock, rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- mode  in  1  transaction type, sampled with the first address bit; 1 = write, 0 = read.
- wr_bus  in  1  serial address/write-data bit, MSB first.
- master_valid  in  1  wr_bus bit valid.
- master_ready  in  1  master accepts the current rd_bus bit.
- rd_bus  out  1  serial read-data bit, MSB first.
- slave_ready  out  1  slave accepts a wr_bus bit this cycle.
- slave_valid  out  1  rd_bus bit valid.
- split  out  1  slave has split the transaction; bus may be released.

## Operation
- Bit transfer rules:
  - An input bit transfers on a cycle with master_valid && slave_ready.
  - An output bit transfers on a cycle with slave_valid && master_ready.
- IDLE:
  - slave_ready=1.
  - On a transfer: latch mode, shift wr_bus into addr_sr, bit_cnt<=1, go to ADDR.
- ADDR:
  - slave_ready=1; each transfer shifts one bit, bit_cnt+1.
  - On the transfer making bit_cnt==ADDR_WIDTH: bit_cnt<=0.
  - Next state: WDATA if mode=1; SPLIT if read and SPLIT_EN=1; RLAT otherwise.
- WDATA:
  - slave_ready=1; shift DATA_WIDTH bits into data_sr.
  - Go to WRITE on the last bit.
- WRITE:
  - slave_ready=0; mem we=1 for exactly one cycle at addr_sr with data_sr.
  - Go to IDLE.
- SPLIT:
  - split=1, slave_ready=0, wait_cnt counts SPLIT_CYCLES cycles, then go to RLAT (split=0 from then on).
- RLAT: two cycles, slave_ready=0.
  - Cycle 1: mem re=1 at addr_sr.
  - Cycle 2: data_sr<=mem q, bit_cnt<=0, go to RDATA.
- RDATA:
  - slave_valid=1, rd_bus=data_sr[MSB].
  - Each output transfer shifts data_sr left and increments bit_cnt.
  - The transfer making bit_cnt==DATA_WIDTH returns to IDLE.
- Stalls:
  - master_valid low in ADDR/WDATA holds state and counters; there is no timeout.
  - master_ready low in RDATA holds rd_bus stable.
- Input bits in non-accepting states (WRITE, SPLIT, RLAT, RDATA) are ignored.
- Addresses wrap within 2^ADDR_WIDTH only by field width; there is no auto-increment and no bursts.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: rd_bus=0, slave_ready=1, slave_valid=0, split=0.
  - Internal: state=IDLE, all counters and shift registers 0.
  - Memory contents are not reset.
- Reset mid-transaction aborts it with no memory write; the partially shifted address/data is discarded.
- Write:
  - Last data bit accepted at edge k; memory updated at edge k+1.
  - slave_ready low for cycle k+1 only, high again from edge k+1.
- Read, no split:
  - Last address bit at edge k.
  - slave_valid first high in the cycle after edge k+2, with the MSB on rd_bus.
- Read with split:
  - split high for cycles k+1..k+SPLIT_CYCLES.
  - slave_valid first high after edge k+SPLIT_CYCLES+2.
- A write followed by a read to the same address returns the new data, since WRITE completes before the next IDLE.
- All outputs are registered or decoded from state/registers only; there are no combinational input-to-output paths.

## Structure
- Shared bus_pkg:
  - slave_port_state_t enum {IDLE, ADDR, WDATA, WRITE, SPLIT, RLAT, RDATA}.
  - Constants MODE_READ=1'b0, MODE_WRITE=1'b1.
- Sub-module slave_mem: simple single-port synchronous RAM.
  - Ports: clk, we, re, addr[ADDR_WIDTH], wdata/rdata[DATA_WIDTH].
  - Registered rdata, one-cycle read latency.
- bit_cnt width is $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1); wait_cnt width is $clog2(SPLIT_CYCLES+1).

## Test plan
- Write then read, defaults:
  - Stimulus: write addr 0x005 data 0xA5, then read addr 0x005.
  - Response: rd_bus shows 1,0,1,0,0,1,0,1; slave_valid drops after 8 transfers.
- Read back-pressure:
  - Stimulus: master_ready toggled 1,0,1,0 during a read of 0x3C.
  - Response: each bit is held while master_ready=0; the byte is correct and complete.
- Valid gaps:
  - Stimulus: 3-cycle master_valid gaps inserted mid-address and mid-data of a write to 0xFFF data 0x81.
  - Response: a subsequent read returns 0x81 and addr 0x000 is unchanged.
- Split read:
  - Stimulus: SPLIT_EN=1, SPLIT_CYCLES=4, read of a preloaded 0x7E.
  - Response: split high for exactly 4 cycles; slave_valid rises 2 cycles after split falls; data 0x7E.
- Reset mid-write:
  - Stimulus: rstn pulsed low after 5 data bits of a write of 0xFF to 0x010.
  - Response: outputs return to reset values immediately; a read of 0x010 returns its prior value.
- Ignored bits:
  - Stimulus: master_valid held high throughout RLAT and RDATA.
  - Response: no state change and no corruption of the read data.
